// File: rtl/avalon_bcd_display_writer_pkg.sv
// Shared types and constants for the BCD display writer.
// SKIP_UNCHANGED_EN (in the top level) enables skipping of unchanged digits.
package avalon_bcd_display_pkg;

    localparam int          NUM_DIGITS_DEF = 6;
    localparam int          BIN_W_DEF      = 20;
    localparam int unsigned MAX_VALUE      = 999999;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_WRITE
    } state_e;

    // Lowest set bit of mask at or above position 'from'; bit 3 of the result flags a hit.
    function automatic logic [3:0] first_set(input logic [7:0] mask, input logic [2:0] from);
        logic [3:0] res;
        res = 4'b0000;
        for (int i = 7; i >= 0; i--) begin
            if (mask[i] && (i >= int'(from))) begin
                res = {1'b1, 3'(i)};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/avalon_bcd_display_writer_if.sv
// Upstream valid/ready value port plus Avalon-MM write master toward the display slave.
interface avalon_bcd_display_writer_if
    import avalon_bcd_display_pkg::*;
#(
    parameter int BIN_W = BIN_W_DEF
);
    logic [BIN_W-1:0] value_i;
    logic             valid_i;
    logic             ready_o;
    logic             overflow_o;
    logic [2:0]       avm_address_o;
    logic [3:0]       avm_byteenable_o;
    logic             avm_write_o;
    logic [31:0]      avm_writedata_o;
    logic             avm_waitrequest_i;

    modport master (
        input  value_i, valid_i, avm_waitrequest_i,
        output ready_o, overflow_o, avm_address_o, avm_byteenable_o,
               avm_write_o, avm_writedata_o
    );

    modport slave (
        output value_i, valid_i, avm_waitrequest_i,
        input  ready_o, overflow_o, avm_address_o, avm_byteenable_o,
               avm_write_o, avm_writedata_o
    );
endinterface

// File: rtl/avalon_bcd_display_writer_bin2bcd_iter.sv
// Iterative double-dabble: one adjust-and-shift step per cycle for BIN_W cycles.
// bcd_o is the accumulator value after the current step; it is final while done_o is high.
module bin2bcd_iter #(
    parameter int BIN_W      = 20,
    parameter int NUM_DIGITS = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic [BIN_W-1:0]        bin_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [4*NUM_DIGITS-1:0] bcd_o
);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    logic [BIN_W-1:0] shift_q, shift_d;
    logic [BCD_W-1:0] acc_q, acc_d, acc_adj;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;

    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
            assign acc_adj[gi*4 +: 4] = (acc_q[gi*4 +: 4] >= 4'd5) ? acc_q[gi*4 +: 4] + 4'd3
                                                                   : acc_q[gi*4 +: 4];
        end
    endgenerate

    assign bcd_o  = {acc_adj[BCD_W-2:0], shift_q[BIN_W-1]};
    assign done_o = (cnt_q == CNT_W'(BIN_W - 1));
    assign busy_o = busy_q;

    always_comb begin
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (start_i) begin
            shift_d = bin_i;
            acc_d   = '0;
            cnt_d   = '0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            shift_d = shift_q << 1;
            acc_d   = bcd_o;
            cnt_d   = cnt_q + 1'b1;
            if (done_o) begin
                busy_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_q <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            shift_q <= shift_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end
endmodule

// File: rtl/avalon_bcd_display_writer.sv
// Accepts a binary value, converts it to BCD and writes each digit to the display slave.
// Define SKIP_UNCHANGED_EN to skip digits that match the last successfully written ones.
module avalon_bcd_display_writer
    import avalon_bcd_display_pkg::*;
#(
    parameter int         NUM_DIGITS    = NUM_DIGITS_DEF,
    parameter int         BIN_W         = BIN_W_DEF,
    parameter logic [3:0] WR_BYTEENABLE = 4'hF
) (
    input  logic                       clk,
    input  logic                       rst,
    avalon_bcd_display_writer_if.master bus_io
);
    localparam int BCD_W = 4 * NUM_DIGITS;

    state_e           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic [BCD_W-1:0] bcd_q;

    logic             conv_start, conv_busy, conv_done, conv_fin;
    logic [BCD_W-1:0] conv_bcd;
    logic             over;
    logic [BIN_W-1:0] sat_value;
    logic [7:0]       write_mask;
    logic [2:0]       search_from;
    logic [3:0]       nxt;
    logic             wr_done;
    bcd_digit_t       cur_digit;

    assign over       = 32'(bus_io.value_i) > MAX_VALUE;
    assign sat_value  = over ? BIN_W'(MAX_VALUE) : bus_io.value_i;
    assign conv_start = (state_q == ST_IDLE) && bus_io.valid_i;
    assign conv_fin   = conv_busy && conv_done;
    assign wr_done    = (state_q == ST_WRITE) && !bus_io.avm_waitrequest_i;
    assign cur_digit  = bcd_q[{idx_q, 2'b00} +: 4];

    bin2bcd_iter #(
        .BIN_W      (BIN_W),
        .NUM_DIGITS (NUM_DIGITS)
    ) u_conv (
        .clk     (clk),
        .rst     (rst),
        .start_i (conv_start),
        .bin_i   (sat_value),
        .busy_o  (conv_busy),
        .done_o  (conv_done),
        .bcd_o   (conv_bcd)
    );

`ifdef SKIP_UNCHANGED_EN
    logic [BCD_W-1:0] shadow_q;
    logic             shadow_valid_q;
    logic [BCD_W-1:0] cmp_bcd;

    // On the final conversion step the fresh result is still combinational.
    assign cmp_bcd = conv_busy ? conv_bcd : bcd_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow_q       <= '0;
            shadow_valid_q <= 1'b0;
        end else if (wr_done) begin
            shadow_q[{idx_q, 2'b00} +: 4] <= cur_digit;
            if (!nxt[3]) begin
                shadow_valid_q <= 1'b1;
            end
        end
    end
`endif

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_mask
            if (gi < NUM_DIGITS) begin : g_digit
`ifdef SKIP_UNCHANGED_EN
                assign write_mask[gi] = !shadow_valid_q ||
                                        (cmp_bcd[gi*4 +: 4] != shadow_q[gi*4 +: 4]);
`else
                assign write_mask[gi] = 1'b1;
`endif
            end else begin : g_pad
                assign write_mask[gi] = 1'b0;
            end
        end
    endgenerate

    assign search_from = (state_q == ST_WRITE) ? idx_q + 3'd1 : 3'd0;
    assign nxt         = first_set(write_mask, search_from);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus_io.valid_i) begin
                    ovf_d   = over;
                    state_d = ST_CONVERT;
                end
            end
            ST_CONVERT: begin
                if (conv_fin) begin
                    if (nxt[3]) begin
                        state_d = ST_WRITE;
                        idx_d   = nxt[2:0];
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 3'd0;
                    end
                end
            end
            ST_WRITE: begin
                if (wr_done) begin
                    if (nxt[3]) begin
                        idx_d = nxt[2:0];
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = 3'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 3'd0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            if (conv_fin) begin
                bcd_q <= conv_bcd;
            end
        end
    end

    // All outputs decode registered state only, so waitrequest/valid never reach them.
    assign bus_io.ready_o          = (state_q == ST_IDLE);
    assign bus_io.overflow_o       = ovf_q;
    assign bus_io.avm_write_o      = (state_q == ST_WRITE);
    assign bus_io.avm_address_o    = idx_q;
    assign bus_io.avm_byteenable_o = (state_q == ST_WRITE) ? WR_BYTEENABLE : 4'h0;
    assign bus_io.avm_writedata_o  = (state_q == ST_WRITE) ? {28'b0, cur_digit} : 32'b0;
endmodule

// File: tb/tb_avalon_bcd_display_writer.sv
// Randomised self-checking bench for avalon_bcd_display_writer against a decimal-digit model.
module tb_avalon_bcd_display_writer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef SKIP_UNCHANGED_EN
    localparam bit SKIP_MODE = 1'b1;
`else
    localparam bit SKIP_MODE = 1'b0;
`endif

    avalon_bcd_display_writer_if #(.BIN_W(20)) bus ();

    avalon_bcd_display_writer dut (
        .clk    (clk),
        .rst    (rst),
        .bus_io (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int addr;
        int data;
        int be;
        int cyc;
    } wr_t;

    wr_t wq[$];
    int  stall_addr = 7;
    int  stall_len = 0;
    int  txn_id = 0;
    int  seen_id = 0;
    int  stall_cnt = 0;
    int  stab_err = 0;
    int  write_cycles = 0;
    bit  prev_stall = 1'b0;
    int  prev_addr, prev_data, prev_be;

    // Model state: last digits the display should hold
    int  shadow[6];
    bit  shadow_ok = 1'b0;
    int unsigned last_value = 0;

    // Slave model: drives waitrequest and records completed writes
    always @(negedge clk) begin
        bit w;
        if (txn_id != seen_id) begin
            seen_id   = txn_id;
            stall_cnt = 0;
        end
        w = 1'b0;
        if (bus.avm_write_o && (int'(bus.avm_address_o) == stall_addr) && (stall_cnt < stall_len)) begin
            w = 1'b1;
            stall_cnt++;
        end
        if (prev_stall && (!bus.avm_write_o || int'(bus.avm_address_o) != prev_addr ||
                           int'(bus.avm_writedata_o) != prev_data || int'(bus.avm_byteenable_o) != prev_be))
            stab_err++;
        prev_stall = w;
        prev_addr  = int'(bus.avm_address_o);
        prev_data  = int'(bus.avm_writedata_o);
        prev_be    = int'(bus.avm_byteenable_o);
        if (bus.avm_write_o) write_cycles++;
        if (bus.avm_write_o && !w)
            wq.push_back('{int'(bus.avm_address_o), int'(bus.avm_writedata_o),
                           int'(bus.avm_byteenable_o), cyc});
        bus.avm_waitrequest_i = w;
    end

    task automatic run_txn(input int unsigned v, input int s_addr, input int s_len, input string tag);
        int dig[6];
        int exp_addr[$];
        int exp_cyc[$];
        int sat, t, q0, se0, e0, rdy_rel, nw;
        bit got;
        sat = (v > 999999) ? 999999 : int'(v);
        for (int i = 0; i < 6; i++) begin
            dig[i] = sat % 10;
            sat    = sat / 10;
        end
        t = 21;
        for (int i = 0; i < 6; i++) begin
            if (!SKIP_MODE || !shadow_ok || dig[i] != shadow[i]) begin
                if (i == s_addr) t += s_len;
                exp_addr.push_back(i);
                exp_cyc.push_back(t);
                t++;
            end
        end
        stall_addr = s_addr;
        stall_len  = s_len;
        txn_id++;
        q0  = wq.size();
        se0 = stab_err;
        @(negedge clk);
        n_tests++;
        if (bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before: got %0b expected 1", tag, bus.ready_o);
        end
        bus.value_i = 20'(v);
        bus.valid_i = 1'b1;
        @(negedge clk);
        e0 = cyc;
        bus.value_i = 20'($urandom_range(0, 1048575));
        got = 1'b0;
        rdy_rel = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            if (bus.ready_o === 1'b1) begin
                got = 1'b1;
                rdy_rel = cyc - e0 + 1;
                bus.valid_i = 1'b0;
            end else begin
                @(negedge clk);
            end
        end
        bus.valid_i = 1'b0;
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL %s ready_timeout: got no ready within 200 cycles expected cycle %0d", tag, t);
        end else if (rdy_rel != t) begin
            n_fail++;
            $display("FAIL %s ready_cycle: got %0d expected %0d", tag, rdy_rel, t);
        end
        n_tests++;
        if (bus.overflow_o !== (v > 999999)) begin
            n_fail++;
            $display("FAIL %s overflow: got %0b expected %0b", tag, bus.overflow_o, (v > 999999));
        end
        nw = wq.size() - q0;
        n_tests++;
        if (nw != exp_addr.size()) begin
            n_fail++;
            $display("FAIL %s write_count: got %0d expected %0d", tag, nw, exp_addr.size());
        end
        for (int j = 0; j < nw && j < exp_addr.size(); j++) begin
            n_tests++;
            if (wq[q0+j].addr != exp_addr[j] || wq[q0+j].data != dig[exp_addr[j]] ||
                wq[q0+j].be != 15 || (wq[q0+j].cyc - e0 + 1) != exp_cyc[j]) begin
                n_fail++;
                $display("FAIL %s write%0d: got addr=%0d data=%0d be=%0d cycle=%0d expected addr=%0d data=%0d be=15 cycle=%0d",
                         tag, j, wq[q0+j].addr, wq[q0+j].data, wq[q0+j].be, wq[q0+j].cyc - e0 + 1,
                         exp_addr[j], dig[exp_addr[j]], exp_cyc[j]);
            end
        end
        n_tests++;
        if (stab_err != se0) begin
            n_fail++;
            $display("FAIL %s stall_stability: got %0d changes expected 0", tag, stab_err - se0);
        end
        foreach (exp_addr[j]) shadow[exp_addr[j]] = dig[exp_addr[j]];
        shadow_ok  = 1'b1;
        last_value = v;
        $display("[TB] txn %s value=%0d writes=%0d ready_cycle=%0d overflow=%0b", tag, v, nw, rdy_rel, bus.overflow_o);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid_i = 1'b0;
        bus.value_i = '0;
        repeat (5) @(negedge clk);
        n_tests++;
        if (bus.ready_o !== 1'b1 || bus.overflow_o !== 1'b0 || bus.avm_write_o !== 1'b0 ||
            bus.avm_address_o !== 3'd0 || bus.avm_byteenable_o !== 4'd0 || bus.avm_writedata_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: got rdy=%0b ovf=%0b wr=%0b addr=%0d be=%0h data=%0h expected 1 0 0 0 0 0",
                     bus.ready_o, bus.overflow_o, bus.avm_write_o, bus.avm_address_o,
                     bus.avm_byteenable_o, bus.avm_writedata_o);
        end
        rst = 1'b0;
        shadow_ok = 1'b0;
        @(negedge clk);
        n_tests++;
        if (bus.ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %0b expected 1", bus.ready_o);
        end
        $display("[TB] txn reset done");
    endtask

    task automatic test_basic();
        run_txn(123456, 7, 0, "basic");
    endtask

    task automatic test_overflow();
        run_txn(20'hFFFFF, 7, 0, "saturate");
        run_txn(42, 7, 0, "after_saturate");
    endtask

    task automatic test_stall();
        run_txn(999999, 2, 3, "stall_addr2");
    endtask

    task automatic test_skip_sequence();
        run_txn(123456, 7, 0, "seq_a");
        run_txn(123459, 7, 0, "seq_b");
        run_txn(123459, 7, 0, "seq_repeat");
    endtask

    task automatic test_random();
        int unsigned v;
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) v = (last_value + $urandom_range(0, 9)) & 32'hFFFFF;
            else v = $urandom_range(0, 1048575);
            run_txn(v, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), "random");
        end
    endtask

    task automatic test_abort();
        int wc0;
        // Reset during CONVERT: no write may ever appear
        @(negedge clk);
        bus.value_i = 20'(last_value);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        wc0 = write_cycles;
        repeat (9) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.ready_o !== 1'b1 || bus.avm_write_o !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_convert_async: got rdy=%0b wr=%0b expected 1 0", bus.ready_o, bus.avm_write_o);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        shadow_ok = 1'b0;
        repeat (30) @(negedge clk);
        n_tests++;
        if (write_cycles != wc0) begin
            n_fail++;
            $display("FAIL abort_no_write: got %0d write cycles expected 0", write_cycles - wc0);
        end
        $display("[TB] txn abort_convert value=%0d", last_value);
        run_txn(last_value, 7, 0, "after_abort");
        // Reset during WRITE drops the strobe immediately
        @(negedge clk);
        bus.value_i = 20'(last_value);
        bus.valid_i = 1'b1;
        @(negedge clk);
        bus.valid_i = 1'b0;
        repeat (21) @(negedge clk);
        n_tests++;
        if (bus.avm_write_o !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_write_pre: got %0b expected 1", bus.avm_write_o);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (bus.avm_write_o !== 1'b0 || bus.avm_byteenable_o !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_write_async: got wr=%0b be=%0h expected 0 0", bus.avm_write_o, bus.avm_byteenable_o);
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        shadow_ok = 1'b0;
        $display("[TB] txn abort_write value=%0d", last_value);
        run_txn(last_value, 7, 0, "after_write_abort");
    endtask

    initial begin
        bus.valid_i = 1'b0;
        bus.value_i = '0;
        test_reset();
        test_basic();
        test_overflow();
        test_stall();
        test_skip_sequence();
        test_random();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
